alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised sequential ALU for the MIPS datapath. It runs single-cycle logic, arithmetic, shift and LUI operations with one-edge registered latency. It also runs iterative multiply (signed and unsigned) and unsigned divide, writing a HI/LO result pair. A start/busy/done handshake lets the controller stall the pipeline while a multi-cycle operation runs.

## Interface
- WIDTH, 32, datapath width; even, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width.
- clk_i  in  1  clock; rising edge active.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  operation request; sampled only when the block can accept.
- ctrl_i  in  4  operation code, sampled with start_i.
- src1_i  in  WIDTH  operand A (rs).
- src2_i  in  WIDTH  operand B (rt / immediate).
- shamt_i  in  SHW  shift amount for SLL/SRL/SRA.
- busy_o  out  1  multi-cycle operation in progress.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  result / LO / quotient.
- hi_o  out  WIDTH  HI / remainder.
- zero_o  out  1  result_o == 0, registered with result_o.
- overflow_o  out  1  signed overflow of ADD/SUB.
- div_by_zero_o  out  1  last DIVU had a zero divisor.

## Operation
- Opcodes (single-cycle):
  - 0000 AND; 0001 OR; 0011 XOR; 1100 NOR.
  - 0010 ADD; 0110 SUB.
  - 0111 SLT (signed); 0101 SLTU. Both write 1/0 zero-extended to WIDTH.
  - 1000 SLL src2<<shamt_i; 1001 SRL; 1010 SRA (arithmetic).
  - 1011 SRAV src2>>>src1_i[SHW-1:0].
  - 1101 LUI src2<<(WIDTH/2).
- Opcodes (multi-cycle): 0100 MULT (signed); 1110 MULTU; 1111 DIVU.
- States:
  - IDLE: start_i accepted. A single-cycle op stays in IDLE. A multi-cycle op captures its operands and moves to RUN with count=WIDTH.
  - RUN: one iteration per edge. count decrements each edge. When count reaches 0, move to FIN.
  - FIN: apply final correction (MULT sign negation), write results, pulse done_o. Accepts start_i exactly as IDLE does, then returns to IDLE or goes to RUN.
- start_i in RUN is ignored. There is no queuing.
- MULT/MULTU:
  - Shift-add over WIDTH iterations, giving a 2·WIDTH product.
  - MULT works on operand magnitudes and negates the product if src1/src2 signs differ. The most-negative operand is handled correctly: (−2^(W−1))² is exact.
  - LO goes to result_o, HI to hi_o.
- DIVU:
  - Restoring division over WIDTH iterations. Quotient goes to result_o, remainder to hi_o.
  - Divisor zero: quotient all-ones, remainder = src1, div_by_zero_o=1. Full latency is still used.
- Flag update rules:
  - hi_o changes only on MULT/MULTU/DIVU completion; otherwise it holds.
  - div_by_zero_o updates only on DIVU completion.
  - overflow_o updates on every completion and is nonzero only for ADD/SUB signed overflow.
- Result hold: result_o/zero_o update on every completion and hold until the next one.

## Timing
- Reset (rst_i low, asynchronous):
  - state IDLE.
  - busy_o=0, done_o=0.
  - result_o=0, hi_o=0.
  - zero_o=1, overflow_o=0, div_by_zero_o=0.
  - Release is synchronous to the next edge.
- Start edge E0 samples start_i. Cycle n is the interval after edge En.
- Single-cycle op: result_o, flags and done_o are valid in cycle 0. done_o drops in cycle 1 unless a new op was started at E1.
- Multi-cycle op:
  - busy_o=1 in cycles 0..WIDTH.
  - FIN is cycle WIDTH+1: done_o=1, busy_o=0, results valid.
  - Latency is WIDTH+1 edges.
- Back-to-back: a start_i high at the edge ending the FIN cycle or a single-cycle done cycle is accepted. This gives one completion per cycle for single-cycle ops.
- Reset during RUN: aborts with no done_o. Results return to reset values.
- Operand inputs may change freely after E0; multi-cycle ops use captured copies.

## Test plan
- Reset: hold rst_i low mid-MULT (cycle 10) -> outputs immediately take reset values; no done_o after release; next ADD 3+4 -> result_o=7 in cycle 0.
- Single-cycle sweep, WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow_o=1.
  - SUB 5−5 -> 0, zero_o=1.
  - SLT −1<1 -> 1.
  - SLTU 0xFFFFFFFF<1 -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - LUI 0x1234 -> 0x12340000.
- MULT −3×7 -> result_o=0xFFFFFFEB, hi_o=0xFFFFFFFF. busy_o for 33 cycles, done_o in cycle 33. start_i pulsed during busy is ignored.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi_o=0xFFFFFFFE, result_o=0x00000001.
- DIVU 100/7 -> result_o=14, hi_o=2. DIVU 9/0 -> result_o=0xFFFFFFFF, hi_o=9, div_by_zero_o=1, latency 33.
- Back-to-back: start_i held high with AND, OR, XOR on consecutive edges -> three consecutive done_o cycles, correct results. A DIVU started in the FIN cycle of a MULT -> accepted, busy_o reasserts next cycle.

Source files
------------

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - sequential MIPS ALU: registered single-cycle ops, iterative MULT/MULTU/DIVU
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             div_by_zero_o
);

  // Iteration counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_MULT  = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SRAV  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  // Control state.
  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic             r_done;

  // Iterative datapath: {r_acc_hi, r_acc_lo} is the product / remainder:quotient pair,
  // r_operand the multiplicand or divisor.
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_operand;
  logic             r_is_div;
  logic             r_negate;

  // Architecturally visible result registers.
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;

  logic             w_accept;
  logic             w_multi;
  logic             w_iterate;
  logic             w_finish;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_mul_addend;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fin;

  // FIN accepts exactly like IDLE; RUN ignores start_i entirely.
  assign w_accept  = start_i && (r_state != S_RUN);
  assign w_multi   = (ctrl_i == OP_MULT) || (ctrl_i == OP_MULTU) || (ctrl_i == OP_DIVU);
  assign w_iterate = (r_state == S_RUN) && (r_count != '0);
  assign w_finish  = (r_state == S_RUN) && (r_count == '0);

  assign w_add = src1_i + src2_i;
  assign w_sub = src1_i - src2_i;
  assign w_add_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (w_add[WIDTH-1] != src1_i[WIDTH-1]);
  assign w_sub_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (w_sub[WIDTH-1] != src1_i[WIDTH-1]);

  // Magnitudes for signed multiply; the most-negative value maps to 2^(W-1), which still fits unsigned.
  assign w_abs1 = src1_i[WIDTH-1] ? (~src1_i + 1'b1) : src1_i;
  assign w_abs2 = src2_i[WIDTH-1] ? (~src2_i + 1'b1) : src2_i;

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_mul_addend = r_acc_lo[0] ? r_operand : '0;
  assign w_mul_sum    = {1'b0, r_acc_hi} + {1'b0, w_mul_addend};

  // Restoring-division step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_rem_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge    = (w_rem_shift >= {1'b0, r_operand});
  assign w_div_diff  = w_rem_shift[WIDTH-1:0] - r_operand;

  // Final sign correction for MULT is applied on the way out of RUN.
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fin = r_negate ? (~w_prod + 1'b1) : w_prod;

  // Single-cycle operation result and signed-overflow flag.
  always_comb begin
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    case (ctrl_i)
      OP_AND:  w_sc_result = src1_i & src2_i;
      OP_OR:   w_sc_result = src1_i | src2_i;
      OP_XOR:  w_sc_result = src1_i ^ src2_i;
      OP_NOR:  w_sc_result = ~(src1_i | src2_i);
      OP_ADD: begin
        w_sc_result = w_add;
        w_sc_ovf    = w_add_ovf;
      end
      OP_SUB: begin
        w_sc_result = w_sub;
        w_sc_ovf    = w_sub_ovf;
      end
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OP_SLL:  w_sc_result = src2_i << shamt_i;
      OP_SRL:  w_sc_result = src2_i >> shamt_i;
      OP_SRA:  w_sc_result = $unsigned($signed(src2_i) >>> shamt_i);
      OP_SRAV: w_sc_result = $unsigned($signed(src2_i) >>> src1_i[SHW-1:0]);
      OP_LUI:  w_sc_result = src2_i << (WIDTH / 2);
      default: w_sc_result = '0;
    endcase
  end

  // Control FSM: state, iteration count and the one-cycle done pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_accept && w_multi) begin
            r_state <= S_RUN;
            r_count <= CW'(WIDTH);
          end else if (w_accept) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_count != '0) begin
            r_count <= r_count - CW'(1);
          end else begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Iterative datapath: capture operands on accept, then one multiply or divide step per RUN edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_operand <= '0;
      r_is_div  <= 1'b0;
      r_negate  <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_acc_hi <= '0;
      case (ctrl_i)
        OP_MULT: begin
          r_acc_lo  <= w_abs1;
          r_operand <= w_abs2;
          r_is_div  <= 1'b0;
          r_negate  <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
        end
        OP_MULTU: begin
          r_acc_lo  <= src1_i;
          r_operand <= src2_i;
          r_is_div  <= 1'b0;
          r_negate  <= 1'b0;
        end
        default: begin
          r_acc_lo  <= src1_i;
          r_operand <= src2_i;
          r_is_div  <= 1'b1;
          r_negate  <= 1'b0;
        end
      endcase
    end else if (w_iterate) begin
      if (r_is_div) begin
        // A zero divisor always passes the trial subtract, yielding all-ones quotient and remainder = dividend.
        r_acc_hi <= w_div_ge ? w_div_diff : w_rem_shift[WIDTH-1:0];
        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
      end else begin
        r_acc_hi <= w_mul_sum[WIDTH:1];
        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Result and flag registers: updated on every completion, held otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept && !w_multi) begin
      r_result <= w_sc_result;
      r_zero   <= (w_sc_result == '0);
      r_ovf    <= w_sc_ovf;
    end else if (w_finish) begin
      r_result <= w_prod_fin[WIDTH-1:0];
      r_hi     <= w_prod_fin[2*WIDTH-1:WIDTH];
      r_zero   <= (w_prod_fin[WIDTH-1:0] == '0);
      r_ovf    <= 1'b0;
      if (r_is_div) begin
        r_dbz <= (r_operand == '0);
      end
    end
  end

  assign busy_o        = (r_state == S_RUN);
  assign done_o        = r_done;
  assign result_o      = r_result;
  assign hi_o          = r_hi;
  assign zero_o        = r_zero;
  assign overflow_o    = r_ovf;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed self-checking bench for alu_iter
module tb_alu_iter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i = 4'b0000;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [31:0] hi_o;
  logic        zero_o;
  logic        overflow_o;
  logic        div_by_zero_o;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;
  int done_cyc;
  int done_seen;

  alu_iter #(.WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ctrl_i        (ctrl_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .shamt_i       (shamt_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .hi_o          (hi_o),
    .zero_o        (zero_o),
    .overflow_o    (overflow_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation for one edge, then scramble operands to prove they were captured.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
    start_i = 1'b1;
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    src1_i  = 32'hA5A5_5A5A;
    src2_i  = 32'h3C3C_C3C3;
  endtask

  // Called in cycle 0 of a multi-cycle op; returns in the done cycle (or after a 40-cycle bound).
  task automatic wait_done(input bit poke, output int bcnt, output int dcyc);
    bcnt = busy_o ? 1 : 0;
    dcyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (poke && c == 6) begin
        start_i = 1'b1;
        ctrl_i  = 4'b0010;
        src1_i  = 32'd1;
        src2_i  = 32'd1;
      end
      if (poke && c == 7) start_i = 1'b0;
      @(posedge clk_i); #1;
      if (busy_o) bcnt++;
      if (done_o) begin
        dcyc = c;
        break;
      end
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_result", result_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_zero", zero_o, 1);
    check("rst_ovf", overflow_o, 0);
    check("rst_dbz", div_by_zero_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single-cycle sweep
    start_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    check("add_res", result_o, 32'h8000_0000);
    check("add_ovf", overflow_o, 1);
    check("add_done", done_o, 1);
    check("add_zero", zero_o, 0);
    start_op(4'b0110, 32'd5, 32'd5, 0);
    check("sub_res", result_o, 0);
    check("sub_zero", zero_o, 1);
    check("sub_ovf", overflow_o, 0);
    start_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt_res", result_o, 1);
    start_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 0);
    check("sltu_res", result_o, 0);
    start_op(4'b1010, 32'h0, 32'h8000_0000, 5'd4);
    check("sra_res", result_o, 32'hF800_0000);
    start_op(4'b1101, 32'h0, 32'h0000_1234, 0);
    check("lui_res", result_o, 32'h1234_0000);
    check("lui_hi_hold", hi_o, 0);
    @(posedge clk_i); #1;
    check("idle_done", done_o, 0);
    check("idle_hold", result_o, 32'h1234_0000);

    // MULT -3 x 7 with a stray start during busy
    start_op(4'b0100, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_busy0", busy_o, 1);
    wait_done(1'b1, busy_cnt, done_cyc);
    check("mult_busy_cycles", busy_cnt, 33);
    check("mult_done_cycle", done_cyc, 33);
    check("mult_lo", result_o, 32'hFFFF_FFEB);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_busy_fin", busy_o, 0);
    @(posedge clk_i); #1;
    check("mult_done_drop", done_o, 0);
    check("mult_no_restart", busy_o, 0);

    // MULTU all-ones squared
    start_op(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("multu_done_cycle", done_cyc, 33);
    check("multu_lo", result_o, 32'h0000_0001);
    check("multu_hi", hi_o, 32'hFFFF_FFFE);

    // MULT most-negative squared
    start_op(4'b0100, 32'h8000_0000, 32'h8000_0000, 0);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("mult_minneg_lo", result_o, 32'h0);
    check("mult_minneg_hi", hi_o, 32'h4000_0000);
    check("mult_minneg_zero", zero_o, 1);

    // DIVU
    start_op(4'b1111, 32'd100, 32'd7, 0);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("divu_q", result_o, 32'd14);
    check("divu_r", hi_o, 32'd2);
    check("divu_dbz", div_by_zero_o, 0);
    start_op(4'b1111, 32'd9, 32'd0, 0);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("div0_done_cycle", done_cyc, 33);
    check("div0_q", result_o, 32'hFFFF_FFFF);
    check("div0_r", hi_o, 32'd9);
    check("div0_dbz", div_by_zero_o, 1);
    @(posedge clk_i); #1;
    start_op(4'b0010, 32'd1, 32'd1, 0);
    check("add_after_div_res", result_o, 32'd2);
    check("add_after_div_hi", hi_o, 32'd9);
    check("add_after_div_dbz", div_by_zero_o, 1);

    // Back-to-back single-cycle ops with start held high
    @(posedge clk_i); #1;
    start_i = 1'b1;
    ctrl_i = 4'b0000; src1_i = 32'h0000_F0F0; src2_i = 32'h0000_FF00;
    @(posedge clk_i); #1;
    check("b2b_and", result_o, 32'h0000_F000);
    check("b2b_and_done", done_o, 1);
    ctrl_i = 4'b0001;
    @(posedge clk_i); #1;
    check("b2b_or", result_o, 32'h0000_FFF0);
    check("b2b_or_done", done_o, 1);
    ctrl_i = 4'b0011;
    @(posedge clk_i); #1;
    check("b2b_xor", result_o, 32'h0000_0FF0);
    check("b2b_xor_done", done_o, 1);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("b2b_end_done", done_o, 0);

    // DIVU launched in the FIN cycle of a MULT
    start_op(4'b0100, 32'd6, 32'd7, 0);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("chain_mult_lo", result_o, 32'd42);
    start_op(4'b1111, 32'd100, 32'd7, 0);
    check("chain_busy", busy_o, 1);
    check("chain_done", done_o, 0);
    check("chain_hold", result_o, 32'd42);
    wait_done(1'b0, busy_cnt, done_cyc);
    check("chain_div_cycle", done_cyc, 33);
    check("chain_div_q", result_o, 32'd14);

    // Reset in the middle of a MULT
    start_op(4'b0100, 32'd5, 32'd5, 0);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("mid_rst_result", result_o, 0);
    check("mid_rst_hi", hi_o, 0);
    check("mid_rst_zero", zero_o, 1);
    check("mid_rst_busy", busy_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (done_o) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    start_op(4'b0010, 32'd3, 32'd4, 0);
    check("post_rst_add", result_o, 32'd7);
    check("post_rst_done", done_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
